clock_divider_multi: RTL and testbench

//  Parametrised multi-channel clock-enable generator for the KGP-RISC core. Each channel

---
 rtl/kgp_clk_pkg.sv | 18 +
 rtl/clk_div_channel.sv | 103 ++++++++++
 rtl/clock_divider_multi.sv | 40 ++++
 tb/tb_clock_divider_multi.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kgp_clk_pkg.sv
// Shared definitions for the KGP-RISC multi-channel clock-enable generator.
// Holds the default channel count, divisor width and reset divisor. The reset
// divisor of 8 gives a half period of 9 cycles, which is the legacy /18 rate.
package kgp_clk_pkg;

  // Default number of independent divider channels (legal range 1..8).
  localparam int unsigned KGP_CH_DEF  = 2;

  // Default width of each channel's half-period divisor D.
  localparam int unsigned KGP_DIV_W   = 8;

  // Divisor loaded into every channel at reset: period 2*(8+1) = 18 cycles.
  localparam int unsigned KGP_DIV_RST = 8;

  // Index type wide enough for the largest supported channel count (8).
  typedef logic [2:0] kgp_ch_idx_t;

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: a half-period counter, an active/pending divisor pair
// and the registered divided clock, rise tick and busy flag.
//
// The counter runs 0..div_act and toggles the output at the terminal count.
// A newly loaded divisor is parked in div_pend and only becomes active on the
// terminal count of a low half, i.e. exactly where the output rises. No half
// period is ever shortened or stretched by a mid-period load.
// Holding the channel (sync strobe or enable low) restarts it from the low
// phase with cnt=0, and any pending divisor takes effect immediately.
module clk_div_channel
  import kgp_clk_pkg::*;
#(
  parameter int unsigned DIV_W   = KGP_DIV_W,
  parameter int unsigned DIV_RST = KGP_DIV_RST
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             sync_i,
  output logic             clk_o,
  output logic             tick_o,
  output logic             busy_o
);

  localparam logic [DIV_W-1:0] LP_DIV_RST = DIV_W'(DIV_RST);
  localparam logic [DIV_W-1:0] LP_ZERO    = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] LP_ONE     = DIV_W'(1);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_div_act;
  logic [DIV_W-1:0] r_div_pend;
  logic             r_pend;
  logic             r_clk;
  logic             r_tick;

  logic             w_term;
  logic             w_rise;
  logic             w_hold;
  logic             w_apply;
  logic [DIV_W-1:0] w_next_div;

  // Decode the terminal count, the hold condition and the divisor to apply.
  // A load in the same cycle as an apply point wins over the older pending value.
  always_comb begin
    w_term  = (r_cnt == r_div_act);
    w_rise  = w_term & ~r_clk;
    w_hold  = sync_i | ~en_i;
    w_apply = w_hold | w_rise;
    if (load_i) begin
      w_next_div = div_i;
    end else if (r_pend) begin
      w_next_div = r_div_pend;
    end else begin
      w_next_div = r_div_act;
    end
  end

  // Divisor bookkeeping: apply at a rise boundary or while held, else park loads.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_div_act  <= LP_DIV_RST;
      r_div_pend <= LP_DIV_RST;
      r_pend     <= 1'b0;
    end else if (w_apply) begin
      r_div_act  <= w_next_div;
      r_div_pend <= w_next_div;
      r_pend     <= 1'b0;
    end else if (load_i) begin
      r_div_pend <= div_i;
      r_pend     <= 1'b1;
    end else begin
      r_div_pend <= r_div_pend;
      r_pend     <= r_pend;
    end
  end

  // Phase counter and registered outputs; hold beats terminal count beats count-up.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt  <= LP_ZERO;
      r_clk  <= 1'b0;
      r_tick <= 1'b0;
    end else if (w_hold) begin
      r_cnt  <= LP_ZERO;
      r_clk  <= 1'b0;
      r_tick <= 1'b0;
    end else if (w_term) begin
      r_cnt  <= LP_ZERO;
      r_clk  <= ~r_clk;
      r_tick <= ~r_clk;
    end else begin
      r_cnt  <= r_cnt + LP_ONE;
      r_tick <= 1'b0;
    end
  end

  assign clk_o  = r_clk;
  assign tick_o = r_tick;
  assign busy_o = r_pend;

endmodule

// File: rtl/clock_divider_multi.sv
// Multi-channel clock-enable generator for the KGP-RISC core.
// Instantiates one clk_div_channel per channel, slices the packed divisor bus
// and fans the common phase-align strobe out to every channel. All outputs
// come straight from channel flops.
module clock_divider_multi
  import kgp_clk_pkg::*;
#(
  parameter int unsigned CH      = KGP_CH_DEF,
  parameter int unsigned DIV_W   = KGP_DIV_W,
  parameter int unsigned DIV_RST = KGP_DIV_RST
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [CH-1:0]       en_i,
  input  logic [CH-1:0]       load_i,
  input  logic [CH*DIV_W-1:0] div_i,
  input  logic                sync_i,
  output logic [CH-1:0]       clk_o,
  output logic [CH-1:0]       tick_o,
  output logic [CH-1:0]       busy_o
);

  for (genvar k = 0; k < CH; k++) begin : g_ch
    clk_div_channel #(
      .DIV_W   (DIV_W),
      .DIV_RST (DIV_RST)
    ) u_chan (
      .clock   (clock),
      .reset_n (reset_n),
      .en_i    (en_i[k]),
      .load_i  (load_i[k]),
      .div_i   (div_i[k*DIV_W +: DIV_W]),
      .sync_i  (sync_i),
      .clk_o   (clk_o[k]),
      .tick_o  (tick_o[k]),
      .busy_o  (busy_o[k])
    );
  end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Self-checking bench for clock_divider_multi (2 channels, 8-bit divisors).
// A countdown model of each channel (remaining cycles in the current half)
// is stepped on every falling edge and compared with the DUT; directed
// sequences add hand-computed period, tick-count and reset expectations.
module tb_clock_divider_multi;

  localparam int CH = 2;
  localparam int DW = 8;

  logic           clock;
  logic           reset_n;
  logic [CH-1:0]  en_i;
  logic [CH-1:0]  load_i;
  logic [CH*DW-1:0] div_i;
  logic           sync_i;
  logic [CH-1:0]  clk_o;
  logic [CH-1:0]  tick_o;
  logic [CH-1:0]  busy_o;

  int total = 0;
  int bad   = 0;

  // model state per channel
  int m_d    [CH];
  int m_pd   [CH];
  int m_rem  [CH];
  bit m_lvl  [CH];
  bit m_tick [CH];
  bit m_pend [CH];

  clock_divider_multi #(.CH(CH), .DIV_W(DW), .DIV_RST(8)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .en_i    (en_i),
    .load_i  (load_i),
    .div_i   (div_i),
    .sync_i  (sync_i),
    .clk_o   (clk_o),
    .tick_o  (tick_o),
    .busy_o  (busy_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < CH; k++) begin
      m_d[k]    = 8;
      m_pd[k]   = 8;
      m_rem[k]  = 9;
      m_lvl[k]  = 1'b0;
      m_tick[k] = 1'b0;
      m_pend[k] = 1'b0;
    end
  endtask

  // One clock edge of the behavioural model, using the inputs seen at that edge.
  task automatic model_step();
    for (int k = 0; k < CH; k++) begin
      int nd;
      bit ld;
      bit apply;
      bit restart;
      ld      = load_i[k];
      nd      = int'(div_i[k*DW +: DW]);
      apply   = 1'b0;
      restart = 1'b0;
      m_tick[k] = 1'b0;
      if (sync_i || !en_i[k]) begin
        m_lvl[k] = 1'b0;
        apply    = 1'b1;
        restart  = 1'b1;
      end else begin
        m_rem[k] = m_rem[k] - 1;
        if (m_rem[k] == 0) begin
          m_lvl[k] = !m_lvl[k];
          restart  = 1'b1;
          if (m_lvl[k]) begin
            m_tick[k] = 1'b1;
            apply     = 1'b1;
          end
        end
      end
      if (apply) begin
        if (ld) m_d[k] = nd;
        else if (m_pend[k]) m_d[k] = m_pd[k];
        m_pend[k] = 1'b0;
      end else if (ld) begin
        m_pd[k]   = nd;
        m_pend[k] = 1'b1;
      end
      if (restart) m_rem[k] = m_d[k] + 1;
    end
  endtask

  // Compare process: step the model and check every output on each falling edge.
  initial begin
    model_reset();
    forever begin
      @(negedge clock);
      if (!reset_n) model_reset();
      else model_step();
      for (int k = 0; k < CH; k++) begin
        chk($sformatf("model clk_o[%0d]", k),  int'(clk_o[k]),  int'(m_lvl[k]));
        chk($sformatf("model tick_o[%0d]", k), int'(tick_o[k]), int'(m_tick[k]));
        chk($sformatf("model busy_o[%0d]", k), int'(busy_o[k]), int'(m_pend[k]));
      end
    end
  end

  // Advance n clock cycles; return 1 time unit after a falling edge.
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clock);
      #1;
    end
  endtask

  initial begin
    int hi;
    int tk0;
    int tk1;
    int acc;
    int n;

    reset_n = 1'b0;
    en_i    = 2'b00;
    load_i  = 2'b00;
    div_i   = 16'h0000;
    sync_i  = 1'b0;

    // reset state
    step(3);
    chk("rst clk_o",  int'(clk_o),  0);
    chk("rst tick_o", int'(tick_o), 0);
    chk("rst busy_o", int'(busy_o), 0);

    // release with default D=8: first rise on the 9th enabled edge, period 18
    reset_n = 1'b1;
    en_i    = 2'b11;
    step(8);
    chk("d8 before rise", int'(clk_o[0]), 0);
    step(1);
    chk("d8 rise clk",  int'(clk_o[0]), 1);
    chk("d8 rise tick", int'(tick_o[0]), 1);
    step(1);
    chk("d8 tick one cycle", int'(tick_o[0]), 0);
    hi  = 0;
    tk0 = 0;
    repeat (18) begin
      step(1);
      hi  += int'(clk_o[0]);
      tk0 += int'(tick_o[0]);
    end
    chk("d8 high cycles per 18", hi, 9);
    chk("d8 ticks per 18", tk0, 1);

    // ch0 D=0, ch1 D=3, phase-aligned: 50 and 12 ticks in a 100-cycle window
    div_i  = {8'd3, 8'd0};
    load_i = 2'b11;
    step(1);
    chk("load busy", int'(busy_o), 3);
    load_i = 2'b00;
    sync_i = 1'b1;
    step(1);
    sync_i = 1'b0;
    chk("sync clears busy", int'(busy_o), 0);
    step(4);
    tk0 = 0;
    tk1 = 0;
    repeat (100) begin
      step(1);
      tk0 += int'(tick_o[0]);
      tk1 += int'(tick_o[1]);
    end
    chk("d0 ticks in 100", tk0, 50);
    chk("d3 ticks in 100", tk1, 12);

    // ch0 D=5, then load D=1 in the high phase: 12-cycle period completes first
    div_i  = {8'd3, 8'd5};
    load_i = 2'b01;
    step(1);
    load_i = 2'b00;
    sync_i = 1'b1;
    step(1);
    sync_i = 1'b0;
    step(5);
    chk("d5 low before rise", int'(clk_o[0]), 0);
    step(1);
    chk("d5 rise clk",  int'(clk_o[0]), 1);
    chk("d5 rise tick", int'(tick_o[0]), 1);
    step(1);
    div_i  = {8'd3, 8'd1};
    load_i = 2'b01;
    step(1);
    load_i = 2'b00;
    chk("mid-high load busy", int'(busy_o[0]), 1);
    step(9);
    chk("old period low end", int'(clk_o[0]), 0);
    chk("busy until rise", int'(busy_o[0]), 1);
    step(1);
    chk("rise after 12", int'(clk_o[0]), 1);
    chk("tick after 12", int'(tick_o[0]), 1);
    chk("busy drops at rise", int'(busy_o[0]), 0);
    step(2);
    chk("d1 fall", int'(clk_o[0]), 0);
    step(2);
    chk("d1 rise period 4", int'(clk_o[0]), 1);
    chk("d1 tick period 4", int'(tick_o[0]), 1);

    // ch1 (D=3, currently high) disabled for 7 cycles, then re-enabled
    en_i = 2'b01;
    acc  = 0;
    repeat (7) begin
      step(1);
      acc += int'(clk_o[1]) + int'(tick_o[1]);
    end
    chk("disabled quiet", acc, 0);
    en_i = 2'b11;
    step(3);
    chk("re-enable before rise", int'(clk_o[1]), 0);
    step(1);
    chk("re-enable rise", int'(clk_o[1]), 1);
    chk("re-enable tick", int'(tick_o[1]), 1);

    // both D=2, ch1 offset by 3 cycles, then sync realigns them
    div_i  = {8'd2, 8'd2};
    load_i = 2'b11;
    step(1);
    load_i = 2'b00;
    sync_i = 1'b1;
    step(1);
    sync_i = 1'b0;
    en_i   = 2'b01;
    step(3);
    en_i = 2'b11;
    acc  = 0;
    repeat (12) begin
      step(1);
      acc += int'(clk_o[0] != clk_o[1]);
    end
    chk("offset channels differ", acc, 12);
    sync_i = 1'b1;
    step(1);
    sync_i = 1'b0;
    acc = 0;
    tk0 = 0;
    tk1 = 0;
    repeat (30) begin
      step(1);
      acc += int'(clk_o[0] == clk_o[1]);
      tk0 += int'(tick_o[0]);
      tk1 += int'(tick_o[1]);
    end
    chk("aligned after sync", acc, 30);
    chk("aligned ticks ch0", tk0, 5);
    chk("aligned ticks ch1", tk1, 5);

    // largest divisor D=255 on ch1: first rise after 256 cycles
    div_i  = {8'hFF, 8'd2};
    load_i = 2'b10;
    step(1);
    load_i = 2'b00;
    sync_i = 1'b1;
    step(1);
    sync_i = 1'b0;
    step(255);
    chk("dmax before rise", int'(clk_o[1]), 0);
    step(1);
    chk("dmax rise", int'(clk_o[1]), 1);
    chk("dmax tick", int'(tick_o[1]), 1);

    // asynchronous reset in a high phase, with a divisor pending on ch1
    div_i  = {8'd7, 8'd2};
    load_i = 2'b10;
    step(1);
    load_i = 2'b00;
    n = 0;
    while (clk_o[0] == 1'b0 && n < 20) begin
      step(1);
      n++;
    end
    chk("reached high phase", int'(clk_o[0]), 1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async rst clk_o",  int'(clk_o),  0);
    chk("async rst tick_o", int'(tick_o), 0);
    chk("async rst busy_o", int'(busy_o), 0);
    step(2);
    reset_n = 1'b1;
    step(8);
    chk("post-rst before rise", int'(clk_o), 0);
    step(1);
    chk("post-rst rise uses reset divisor", int'(clk_o), 3);
    chk("post-rst tick", int'(tick_o), 3);

    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
